// File: rtl/streaming_data_width_converter.sv
// AXI-Stream width converter: LSB-first packing (narrow->wide),
// LSB-first splitting (wide->narrow) or a single-register pass-through.
module streaming_data_width_converter #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [IN_WIDTH-1:0]  in0_V_V_TDATA,
  input  logic                 in0_V_V_TVALID,
  output logic                 in0_V_V_TREADY,
  output logic [OUT_WIDTH-1:0] out_V_V_TDATA,
  output logic                 out_V_V_TVALID,
  input  logic                 out_V_V_TREADY
);

  localparam int MAXW = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int MINW = (IN_WIDTH > OUT_WIDTH) ? OUT_WIDTH : IN_WIDTH;
  localparam int K    = MAXW / MINW;

  logic [OUT_WIDTH-1:0] r_data;
  logic                 r_valid;
  logic                 w_ready;
  logic                 w_acc;

  assign out_V_V_TDATA  = r_data;
  assign out_V_V_TVALID = r_valid;
  assign in0_V_V_TREADY = w_ready;
  assign w_acc          = in0_V_V_TVALID && w_ready;

  if ((MAXW % MINW) != 0) begin : g_bad
    $error("IN_WIDTH and OUT_WIDTH must be integer multiples");
  end

  if (OUT_WIDTH > IN_WIDTH) begin : g_up
    localparam int CW = $clog2(K);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    logic [CW-1:0]               r_cnt;
    logic [(K-1)*IN_WIDTH-1:0]   r_buf;

    // The last word of a group only waits when the output is stalled.
    assign w_ready = (r_cnt != LAST) || !r_valid || out_V_V_TREADY;

    // Pack words LSB-first; the K-th word goes straight to the output.
    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
        r_cnt   <= '0;
        r_buf   <= '0;
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        if (r_valid && out_V_V_TREADY) r_valid <= 1'b0;
        if (w_acc) begin
          if (r_cnt == LAST) begin
            r_data  <= {in0_V_V_TDATA, r_buf};
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_buf[r_cnt*IN_WIDTH +: IN_WIDTH] <= in0_V_V_TDATA;
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end else if (IN_WIDTH > OUT_WIDTH) begin : g_dn
    localparam int CW = $clog2(K);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    logic [IN_WIDTH-1:0] r_held;
    logic [CW-1:0]       r_idx;
    logic [CW-1:0]       w_nidx;
    logic                w_last;

    assign w_nidx  = r_idx + 1'b1;
    assign w_last  = (r_idx == LAST);
    assign w_ready = !r_valid || (w_last && out_V_V_TREADY);

    // Hold the wide word and step through its slices on each transfer.
    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
        r_held  <= '0;
        r_idx   <= '0;
        r_data  <= '0;
        r_valid <= 1'b0;
      end else if (w_acc) begin
        r_held  <= in0_V_V_TDATA;
        r_idx   <= '0;
        r_data  <= in0_V_V_TDATA[OUT_WIDTH-1:0];
        r_valid <= 1'b1;
      end else if (r_valid && out_V_V_TREADY) begin
        if (w_last) begin
          r_valid <= 1'b0;
        end else begin
          r_idx  <= w_nidx;
          r_data <= r_held[w_nidx*OUT_WIDTH +: OUT_WIDTH];
        end
      end
    end
  end else begin : g_pass
    assign w_ready = !r_valid || out_V_V_TREADY;

    // Single skid-free output register.
    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else if (w_acc) begin
        r_data  <= in0_V_V_TDATA;
        r_valid <= 1'b1;
      end else if (out_V_V_TREADY) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_streaming_data_width_converter.sv
// Bench for the width converter: UP 8->32, DOWN 32->8, PASS 8->8
// instances with a queue scoreboard per instance.
module tb_streaming_data_width_converter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  logic [7:0]  up_in_d;
  logic        up_in_v, up_in_r;
  logic [31:0] up_out_d;
  logic        up_out_v, up_out_r;

  logic [31:0] dn_in_d;
  logic        dn_in_v, dn_in_r;
  logic [7:0]  dn_out_d;
  logic        dn_out_v, dn_out_r;

  logic [7:0]  ps_in_d;
  logic        ps_in_v, ps_in_r;
  logic [7:0]  ps_out_d;
  logic        ps_out_v, ps_out_r;

  streaming_data_width_converter #(.IN_WIDTH(8), .OUT_WIDTH(32)) u_up (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_V_TDATA(up_in_d), .in0_V_V_TVALID(up_in_v),
    .in0_V_V_TREADY(up_in_r),
    .out_V_V_TDATA(up_out_d), .out_V_V_TVALID(up_out_v),
    .out_V_V_TREADY(up_out_r)
  );

  streaming_data_width_converter #(.IN_WIDTH(32), .OUT_WIDTH(8)) u_dn (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_V_TDATA(dn_in_d), .in0_V_V_TVALID(dn_in_v),
    .in0_V_V_TREADY(dn_in_r),
    .out_V_V_TDATA(dn_out_d), .out_V_V_TVALID(dn_out_v),
    .out_V_V_TREADY(dn_out_r)
  );

  streaming_data_width_converter #(.IN_WIDTH(8), .OUT_WIDTH(8)) u_ps (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_V_TDATA(ps_in_d), .in0_V_V_TVALID(ps_in_v),
    .in0_V_V_TREADY(ps_in_r),
    .out_V_V_TDATA(ps_out_d), .out_V_V_TVALID(ps_out_v),
    .out_V_V_TREADY(ps_out_r)
  );

  logic [31:0] q_up[$];
  logic [31:0] q_dn[$];
  logic [31:0] q_ps[$];
  int          dn_times[$];
  logic [31:0] up_acc = '0;
  int          up_n = 0;
  bit          dn_rand = 1'b0;
  bit          ps_alt = 1'b0;
  logic        dn_stall = 1'b0;
  logic [7:0]  dn_prev = '0;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    nchk++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Output-ready drivers for the DOWN and PASS instances.
  initial begin
    dn_out_r = 1'b1;
    ps_out_r = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dn_out_r = dn_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      ps_out_r = ps_alt ? ~ps_out_r : 1'b1;
    end
  end

  // Scoreboard: a transfer happens at the next edge when valid&&ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      dn_stall = 1'b0;
    end else begin
      if (up_out_v && up_out_r) begin
        if (q_up.size() == 0) chk("up_extra", 32'(up_out_v), 32'd0);
        else chk("up_data", up_out_d, q_up.pop_front());
      end
      if (dn_out_v && dn_out_r) begin
        dn_times.push_back(cyc);
        if (q_dn.size() == 0) chk("dn_extra", 32'(dn_out_v), 32'd0);
        else chk("dn_data", 32'(dn_out_d), q_dn.pop_front());
      end
      if (ps_out_v && ps_out_r) begin
        if (q_ps.size() == 0) chk("ps_extra", 32'(ps_out_v), 32'd0);
        else chk("ps_data", 32'(ps_out_d), q_ps.pop_front());
      end
      if (dn_stall) begin
        chk("dn_hold_v", 32'(dn_out_v), 32'd1);
        chk("dn_hold_d", 32'(dn_out_d), 32'(dn_prev));
      end
      dn_stall = dn_out_v && !dn_out_r;
      dn_prev  = dn_out_d;
    end
  end

  task automatic up_put(input logic [7:0] d, output int w);
    w = 0;
    up_in_d = d;
    up_in_v = 1'b1;
    @(negedge clk);
    while (!up_in_r && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("up_accept", 32'(up_in_r), 32'd1);
    @(posedge clk);
    #1;
    up_in_v = 1'b0;
    up_acc = {d, up_acc[31:8]};
    up_n++;
    if (up_n == 4) begin
      q_up.push_back(up_acc);
      up_n = 0;
    end
  endtask

  task automatic dn_put(input logic [31:0] d, output int w);
    w = 0;
    dn_in_d = d;
    dn_in_v = 1'b1;
    @(negedge clk);
    while (!dn_in_r && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("dn_accept", 32'(dn_in_r), 32'd1);
    @(posedge clk);
    #1;
    dn_in_v = 1'b0;
    for (int i = 0; i < 4; i++) q_dn.push_back(32'(d[i*8 +: 8]));
  endtask

  task automatic ps_put(input logic [7:0] d, output int w);
    w = 0;
    ps_in_d = d;
    ps_in_v = 1'b1;
    @(negedge clk);
    while (!ps_in_r && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("ps_accept", 32'(ps_in_r), 32'd1);
    @(posedge clk);
    #1;
    ps_in_v = 1'b0;
    q_ps.push_back(32'(d));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q_up.size() + q_dn.size() + q_ps.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q_up.size() + q_dn.size() + q_ps.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int b;
    logic [7:0] v;

    rst_n = 1'b0;
    up_in_d = '0; up_in_v = 1'b0; up_out_r = 1'b1;
    dn_in_d = '0; dn_in_v = 1'b0;
    ps_in_d = '0; ps_in_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_up_v", 32'(up_out_v), 32'd0);
    chk("rst_up_d", up_out_d, 32'd0);
    chk("rst_dn_v", 32'(dn_out_v), 32'd0);
    chk("rst_dn_d", 32'(dn_out_d), 32'd0);
    chk("rst_ps_v", 32'(ps_out_v), 32'd0);
    chk("rst_up_r", 32'(up_in_r), 32'd1);
    chk("rst_dn_r", 32'(dn_in_r), 32'd1);
    chk("rst_ps_r", 32'(ps_in_r), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // UP streaming, output always ready
    for (int i = 0; i < 8; i++) begin
      v = 8'(17 * (i + 1));
      up_put(v, w);
      chk("up1_nowait", 32'(w), 32'd0);
      chk("up1_valid", 32'(up_out_v), 32'((i % 4) == 3));
      if (i == 3) chk("up1_w0", up_out_d, 32'h44332211);
      if (i == 7) chk("up1_w1", up_out_d, 32'h88776655);
    end
    wait_drain();

    // UP with output stalled after the first word
    up_out_r = 1'b0;
    for (int i = 0; i < 7; i++) begin
      v = 8'(17 * (i + 1));
      up_put(v, w);
      chk("up2_nowait", 32'(w), 32'd0);
    end
    up_in_d = 8'h88;
    up_in_v = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("up2_inrdy", 32'(up_in_r), 32'd0);
      chk("up2_v", 32'(up_out_v), 32'd1);
      chk("up2_hold", up_out_d, 32'h44332211);
    end
    @(posedge clk);
    #1;
    up_out_r = 1'b1;
    up_put(8'h88, w);
    chk("up2_resume", 32'(w), 32'd0);
    wait_drain();

    // DOWN back-to-back, output always ready
    b = dn_times.size();
    dn_put(32'hDEADBEEF, w);
    chk("dn3_w0", 32'(w), 32'd0);
    chk("dn3_lat_v", 32'(dn_out_v), 32'd1);
    chk("dn3_lat_d", 32'(dn_out_d), 32'hEF);
    dn_put(32'h01020304, w);
    chk("dn3_w1", 32'(w), 32'd3);
    wait_drain();
    chk("dn3_count", 32'(dn_times.size() - b), 32'd8);
    if (dn_times.size() >= b + 8)
      chk("dn3_nobubble", 32'(dn_times[b+7] - dn_times[b]), 32'd7);

    // DOWN with random output backpressure
    dn_rand = 1'b1;
    for (int i = 0; i < 1000; i++) dn_put($urandom, w);
    wait_drain();
    dn_rand = 1'b0;

    // Reset in the middle of an UP group
    up_put(8'h01, w);
    up_put(8'h02, w);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst5_v_in", 32'(up_out_v), 32'd0);
    @(posedge clk);
    #1;
    chk("rst5_v", 32'(up_out_v), 32'd0);
    chk("rst5_d", up_out_d, 32'd0);
    chk("rst5_r", 32'(up_in_r), 32'd1);
    rst_n = 1'b1;
    up_n = 0;
    up_acc = '0;
    for (int i = 0; i < 4; i++) up_put(8'(8'hA0 + i), w);
    chk("rst5_first", up_out_d, 32'hA3A2A1A0);
    wait_drain();

    // PASS with alternating output ready
    ps_alt = 1'b1;
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      ps_put(v, w);
      chk("ps_lat_v", 32'(ps_out_v), 32'd1);
      chk("ps_lat_d", 32'(ps_out_d), 32'(v));
    end
    wait_drain();
    ps_alt = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
